// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and timing helper for the non-restoring divider
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        ITER,
        FIX,
        OUT_Q,
        OUT_R
    } div_state_e;

    // Cycles from the accepted enable to the cycle in which done is high.
    function automatic int div_latency(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// rtl/div_nr_step.sv - one combinational non-restoring division step on {P,Q} with divisor M
module div_nr_step #(
    parameter int W = 8
) (
    input  logic [W:0]   p_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] m_i,
    output logic [W:0]   p_o,
    output logic [W-1:0] q_o
);

    logic [W:0] shifted;
    logic [W:0] m_ext;

    // P is kept in W+1 bits; the intermediate shift may wrap but the
    // post-add/subtract result always lies in [-M, M) and is exact.
    always_comb begin
        shifted = {p_i[W-1:0], q_i[W-1]};
        m_ext   = {1'b0, m_i};
        p_o     = p_i[W] ? (shifted + m_ext) : (shifted - m_ext);
        q_o     = {q_i[W-2:0], ~p_o[W]};
    end

endmodule

// File: rtl/div_nonrestoring_param.sv
// rtl/div_nonrestoring_param.sv - serial-bus sequential W-bit divider, optional signed mode
module div_nonrestoring_param #(
    parameter int W      = 8,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [W-1:0] inbus,
    output logic [W-1:0] outbus,
    output logic         done,
    output logic         rem_valid,
    output logic         busy,
    output logic         dbz,
    output logic         ovf
);
    import div_pkg::*;

    localparam int         CW      = $clog2(W);
    localparam logic       SGN     = (SIGNED != 0);
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    div_state_e    state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  m_q;
    logic [W:0]    p_q;
    logic [W-1:0]  qr_q;
    logic [CW-1:0] cnt_q;
    logic          sa_q;
    logic          sb_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  outbus_q;
    logic          done_q;
    logic          rem_valid_q;
    logic          busy_q;
    logic          dbz_q;
    logic          ovf_q;

    logic [W:0]    p_d;
    logic [W-1:0]  q_d;

    logic          neg_a;
    logic          neg_b;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  rem_mag;
    logic [W-1:0]  quo_fix;
    logic [W-1:0]  rem_fix;
    logic          ovf_hit;

    div_nr_step #(.W(W)) u_step (
        .p_i (p_q),
        .q_i (qr_q),
        .m_i (m_q),
        .p_o (p_d),
        .q_o (q_d)
    );

    // Remainder correction is done modulo 2^W: the corrected value is in [0, M).
    always_comb begin
        neg_a   = SGN && a_q[W-1];
        neg_b   = SGN && inbus[W-1];
        a_mag   = neg_a ? -a_q : a_q;
        b_mag   = neg_b ? -inbus : inbus;
        rem_mag = p_q[W] ? (p_q[W-1:0] + m_q) : p_q[W-1:0];
        quo_fix = (sa_q ^ sb_q) ? -qr_q : qr_q;
        rem_fix = sa_q ? -rem_mag : rem_mag;
        ovf_hit = sa_q && sb_q && (a_q == MOST_NEG) && (m_q == ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            m_q         <= '0;
            p_q         <= '0;
            qr_q        <= '0;
            cnt_q       <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            rem_q       <= '0;
            outbus_q    <= '0;
            done_q      <= 1'b0;
            rem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q      <= 1'b0;
                    rem_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    if (enable) begin
                        a_q     <= inbus;
                        dbz_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD_M;
                    end
                end
                LOAD_M: begin
                    m_q  <= b_mag;
                    sa_q <= neg_a;
                    sb_q <= neg_b;
                    p_q  <= '0;
                    qr_q <= a_mag;
                    if (inbus == '0) begin
                        outbus_q <= ALL_ONES;
                        rem_q    <= a_q;
                        dbz_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= OUT_Q;
                    end else begin
                        cnt_q   <= CW'(W - 1);
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    p_q   <= p_d;
                    qr_q  <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    outbus_q <= quo_fix;
                    rem_q    <= ovf_hit ? '0 : rem_fix;
                    ovf_q    <= ovf_hit;
                    done_q   <= 1'b1;
                    state_q  <= OUT_Q;
                end
                OUT_Q: begin
                    done_q      <= 1'b0;
                    rem_valid_q <= 1'b1;
                    outbus_q    <= rem_q;
                    state_q     <= OUT_R;
                end
                OUT_R: begin
                    rem_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign outbus    = outbus_q;
    assign done      = done_q;
    assign rem_valid = rem_valid_q;
    assign busy      = busy_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_nonrestoring_param.sv
// tb/tb_div_nonrestoring_param.sv - scoreboard bench: W=8 unsigned, W=8 signed, W=16 unsigned
module tb_div_nonrestoring_param;

    typedef struct {
        int          k;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          start;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  en;
    logic [7:0]  ib0;
    logic [7:0]  ib1;
    logic [15:0] ib2;
    wire  [7:0]  ob0;
    wire  [7:0]  ob1;
    wire  [15:0] ob2;
    wire  [2:0]  dn;
    wire  [2:0]  rv;
    wire  [2:0]  bsy;
    wire  [2:0]  dz;
    wire  [2:0]  ov;

    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    exp_t pend[3];
    logic [2:0] rem_pend;

    div_nonrestoring_param #(.W(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .inbus(ib0), .outbus(ob0),
        .done(dn[0]), .rem_valid(rv[0]), .busy(bsy[0]), .dbz(dz[0]), .ovf(ov[0])
    );
    div_nonrestoring_param #(.W(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .inbus(ib1), .outbus(ob1),
        .done(dn[1]), .rem_valid(rv[1]), .busy(bsy[1]), .dbz(dz[1]), .ovf(ov[1])
    );
    div_nonrestoring_param #(.W(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .inbus(ib2), .outbus(ob2),
        .done(dn[2]), .rem_valid(rv[2]), .busy(bsy[2]), .dbz(dz[2]), .ovf(ov[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic int wid(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic logic [15:0] get_out(input int k);
        case (k)
            0:       return {8'h00, ob0};
            1:       return {8'h00, ob1};
            default: return ob2;
        endcase
    endfunction

    task automatic set_in(input int k, input logic [15:0] v);
        case (k)
            0:       ib0 = v[7:0];
            1:       ib1 = v[7:0];
            default: ib2 = v;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; SV '/' and '%' truncate toward zero.
    function automatic exp_t model(input int k, input logic [15:0] a_in, input logic [15:0] b_in);
        exp_t   e;
        int     w;
        longint msk;
        longint half;
        longint a;
        longint b;
        longint qv;
        longint rv_;
        w    = wid(k);
        msk  = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        a    = longint'(a_in) & msk;
        b    = longint'(b_in) & msk;
        e.k  = k;
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.lat = w + 3;
        e.start = 0;
        if (b == 0) begin
            e.q   = 16'(msk);
            e.r   = 16'(a);
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            if (k == 1) begin
                if (a >= half) a = a - (msk + 1);
                if (b >= half) b = b - (msk + 1);
                if (a == -half && b == -1) e.ov = 1'b1;
            end
            qv  = a / b;
            rv_ = a % b;
            e.q = 16'(qv & msk);
            e.r = 16'(rv_ & msk);
        end
        return e;
    endfunction

    // Called at posedge+1 with the instance idle; returns at posedge+1 of
    // cycle W+5, so consecutive calls on one instance are back-to-back.
    task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b, input bit poke);
        exp_t   e;
        int     w;
        int     occ;
        longint msk;
        w   = wid(k);
        msk = (longint'(1) << w) - 1;
        e = model(k, a, b);
        e.start = cyc;
        sb.push_back(e);
        en[k] = 1'b1;
        set_in(k, a);
        @(posedge clk); #1;
        en[k] = 1'b0;
        set_in(k, b);
        check("busy_cycle1", bsy[k], 1);
        @(posedge clk); #1;
        occ = ((longint'(b) & msk) == 0) ? 4 : w + 5;
        for (int c = 2; c < w + 5; c++) begin
            check("busy", bsy[k], (c < occ) ? 1 : 0);
            set_in(k, 16'($urandom));
            en[k] = poke && (c == 3);
            @(posedge clk); #1;
        end
        en[k] = 1'b0;
        check("busy_after", bsy[k], 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    if (rem_pend[k]) begin
                        check("rem_valid", rv[k], 1);
                        check("remainder", get_out(k), pend[k].r);
                        check("dbz_rem", dz[k], pend[k].dz);
                        check("ovf_rem", ov[k], pend[k].ov);
                        rem_pend[k] = 1'b0;
                    end else if (rv[k]) begin
                        check("spurious_rem_valid", rv[k], 0);
                    end
                    if (dn[k]) begin
                        if (sb.size() == 0) begin
                            check("spurious_done", dn[k], 0);
                        end else begin
                            e = sb.pop_front();
                            check("done_instance", k, e.k);
                            check("quotient", get_out(k), e.q);
                            check("latency", cyc - e.start, e.lat);
                            check("dbz", dz[k], e.dz);
                            check("ovf", ov[k], e.ov);
                            pend[k] = e;
                            rem_pend[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        n_chk    = 0;
        n_fail   = 0;
        rem_pend = 3'b000;
        rst_n    = 1'b0;
        en       = 3'b000;
        ib0      = '0;
        ib1      = '0;
        ib2      = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_outbus", get_out(k), 0);
            check("reset_done", dn[k], 0);
            check("reset_rem_valid", rv[k], 0);
            check("reset_busy", bsy[k], 0);
            check("reset_dbz", dz[k], 0);
            check("reset_ovf", ov[k], 0);
        end
        rst_n = 1'b1;

        issue(0, 16'd10,   16'd4,   1'b1);
        issue(0, 16'd255,  16'd1,   1'b0);
        issue(0, 16'd3,    16'd200, 1'b0);
        issue(0, 16'h5A,   16'd0,   1'b1);
        issue(0, 16'd255,  16'd7,   1'b0);
        issue(1, 16'hF9,   16'd2,   1'b0);
        issue(1, 16'd7,    16'hFE,  1'b1);
        issue(1, 16'h80,   16'hFF,  1'b0);
        issue(1, 16'h5A,   16'd0,   1'b0);
        issue(1, 16'h80,   16'd1,   1'b0);
        issue(2, 16'd50000, 16'd123, 1'b0);
        issue(2, 16'd50000, 16'd123, 1'b1);
        issue(2, 16'hFFFF, 16'hFFFF, 1'b0);

        for (int n = 0; n < 36; n++) begin
            int k;
            k = n % 3;
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if (k == 1 && $urandom_range(0, 5) == 0) begin
                a = 16'h0080;
                b = 16'h00FF;
            end
            issue(k, a, b, ($urandom_range(0, 3) == 0));
        end

        // Abort a division mid-ITER with an asynchronous reset.
        issue(0, 16'd255, 16'd7, 1'b0);
        en[0] = 1'b1;
        ib0   = 8'd200;
        @(posedge clk); #1;
        en[0] = 1'b0;
        ib0   = 8'd9;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outbus", ob0, 0);
        check("abort_done", dn[0], 0);
        check("abort_rem_valid", rv[0], 0);
        check("abort_busy", bsy[0], 0);
        check("abort_dbz", dz[0], 0);
        check("abort_ovf", ov[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(0, 16'd200, 16'd9, 1'b0);
        issue(1, 16'h81,  16'd3, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("remainders_drained", rem_pend, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
